// File: rtl/wb_keyreg_arb.sv
// wb_keyreg_arb: round-robin Wishbone B3 arbiter for NM masters onto one RAM
// slave port, with a local key/lock register window that never reaches RAM.
// Handshake: a master owns the shared port from the cycle after it is granted
// until it drops cyc; a transfer completes in the cycle where the master's stb
// is high and its ack (or err) is high; one cycle with no owner separates
// consecutive owners.
module wb_keyreg_arb #(
  parameter int              NM           = 3,
  parameter int              DW           = 32,
  parameter int              AW           = 32,
  parameter int              NUM_KEYS     = 6,
  parameter int              KEY_W        = 128,
  parameter logic [19:0]     KEY_BASE     = 20'h80000,
  parameter logic [NM-1:0]   KEY_WR_MASK  = NM'(1),
  parameter bit              KEY_READBACK = 1'b0
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NM*AW-1:0]          m_adr_i,
  input  logic [NM*DW-1:0]          m_dat_i,
  input  logic [NM*4-1:0]           m_sel_i,
  input  logic [NM*3-1:0]           m_cti_i,
  input  logic [NM*2-1:0]           m_bte_i,
  input  logic [NM-1:0]             m_cyc_i,
  input  logic [NM-1:0]             m_stb_i,
  input  logic [NM-1:0]             m_we_i,
  output logic [DW-1:0]             m_dat_o,
  output logic [NM-1:0]             m_ack_o,
  output logic [NM-1:0]             m_err_o,
  output logic [NM-1:0]             m_rty_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  input  logic [DW-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  output logic [NUM_KEYS*KEY_W-1:0] keys_o,
  output logic                      key_locked_o
);

  localparam int         GW       = (NM > 1) ? $clog2(NM) : 1;
  localparam int         KW       = KEY_W / DW;
  localparam int         NW       = NUM_KEYS * KW;
  localparam logic [7:0] LOCK_IDX = 8'(NW);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                    state;
  logic [GW-1:0]             grant, last_grant, next_grant;
  logic                      found;
  logic [AW-1:0]             g_adr;
  logic [DW-1:0]             g_dat;
  logic [3:0]                g_sel;
  logic [2:0]                g_cti;
  logic [1:0]                g_bte;
  logic                      g_cyc, g_stb, g_we, g_wr_ok;
  logic                      in_win, is_key, is_lock, hit, err_cond;
  logic [7:0]                word_idx;
  logic [DW-1:0]             loc_rd, rd_q;
  logic                      ack_q, err_q, locked_q;
  logic [NUM_KEYS*KEY_W-1:0] keys_q;
  logic                      loc_ack, loc_err;

  // Next owner: first requester above last_grant, then wrap to the lowest.
  always_comb begin
    next_grant = last_grant;
    found      = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (!found && m_cyc_i[i] && (GW'(i) > last_grant)) begin
        next_grant = GW'(i);
        found      = 1'b1;
      end
    end
    for (int i = 0; i < NM; i++) begin
      if (!found && m_cyc_i[i] && (GW'(i) <= last_grant)) begin
        next_grant = GW'(i);
        found      = 1'b1;
      end
    end
  end

  // Select the granted master's request signals.
  always_comb begin
    g_adr   = '0;
    g_dat   = '0;
    g_sel   = '0;
    g_cti   = '0;
    g_bte   = '0;
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    g_we    = 1'b0;
    g_wr_ok = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (grant == GW'(i)) begin
        g_adr   = m_adr_i[i*AW +: AW];
        g_dat   = m_dat_i[i*DW +: DW];
        g_sel   = m_sel_i[i*4 +: 4];
        g_cti   = m_cti_i[i*3 +: 3];
        g_bte   = m_bte_i[i*2 +: 2];
        g_cyc   = m_cyc_i[i];
        g_stb   = m_stb_i[i];
        g_we    = m_we_i[i];
        g_wr_ok = KEY_WR_MASK[i];
      end
    end
  end

  // Key window decode on the low 20 address bits; base is word aligned.
  assign in_win   = ({1'b0, g_adr[19:0]} >= {1'b0, KEY_BASE}) &&
                    ({1'b0, g_adr[19:0]} <= ({1'b0, KEY_BASE} + 21'h0FF));
  assign word_idx = {2'b00, g_adr[7:2] - KEY_BASE[7:2]};
  assign is_key   = (word_idx < LOCK_IDX);
  assign is_lock  = (word_idx == LOCK_IDX);
  assign hit      = (state == GRANT) && g_cyc && g_stb && in_win;
  assign err_cond = (!is_key && !is_lock) || (g_we && locked_q) || (g_we && !g_wr_ok);

  // Local read word: lock flag, or key word when readback is enabled.
  always_comb begin
    loc_rd = '0;
    if (is_lock) begin
      loc_rd = {{(DW-1){1'b0}}, locked_q};
    end else if (KEY_READBACK) begin
      for (int w = 0; w < NW; w++) begin
        if (word_idx == 8'(w)) loc_rd = keys_q[w*DW +: DW];
      end
    end
  end

  // Arbiter FSM: grant in IDLE, hold the owner until it drops cyc.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NM-1);
    end else begin
      case (state)
        IDLE: begin
          if (|m_cyc_i) begin
            grant      <= next_grant;
            last_grant <= next_grant;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (!g_cyc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Local response: one-cycle pulse after a window hit, err flag and read data captured with it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      ack_q <= hit && !ack_q;
      if (hit && !ack_q) begin
        err_q <= err_cond;
        rd_q  <= loc_rd;
      end
    end
  end

  // Key and lock writes commit on the edge that raises the local response.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      keys_q   <= '0;
      locked_q <= 1'b0;
    end else if (hit && !ack_q && g_we && !err_cond) begin
      if (is_lock) begin
        if (g_dat[0]) locked_q <= 1'b1;
      end else begin
        for (int w = 0; w < NW; w++) begin
          for (int b = 0; b < 4; b++) begin
            if ((word_idx == 8'(w)) && g_sel[b]) keys_q[w*DW + b*8 +: 8] <= g_dat[b*8 +: 8];
          end
        end
      end
    end
  end

  // A local response is dropped if the owner has already released the bus.
  assign loc_ack = ack_q && !err_q && g_cyc;
  assign loc_err = ack_q && err_q && g_cyc;

  // Route responses to the owner only.
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    for (int i = 0; i < NM; i++) begin
      m_ack_o[i] = (state == GRANT) && (grant == GW'(i)) && (loc_ack || s_ack_i);
      m_err_o[i] = (state == GRANT) && (grant == GW'(i)) && (loc_err || s_err_i);
    end
  end

  assign m_rty_o      = '0;
  assign m_dat_o      = ack_q ? rd_q : s_dat_i;
  assign s_adr_o      = (state == GRANT) ? g_adr : '0;
  assign s_dat_o      = (state == GRANT) ? g_dat : '0;
  assign s_sel_o      = (state == GRANT) ? g_sel : '0;
  assign s_cti_o      = (state == GRANT) ? g_cti : '0;
  assign s_bte_o      = (state == GRANT) ? g_bte : '0;
  assign s_we_o       = (state == GRANT) && g_we;
  assign s_cyc_o      = (state == GRANT) && g_cyc && !in_win;
  assign s_stb_o      = (state == GRANT) && g_stb && !in_win;
  assign keys_o       = keys_q;
  assign key_locked_o = locked_q;

endmodule

// File: tb/tb_wb_keyreg_arb.sv
// Directed bench for wb_keyreg_arb: key writes, permission and lock errors,
// round-robin ownership, reset mid-transaction and an aborted key write.
module tb_wb_keyreg_arb;

  localparam int NM = 3, DW = 32, AW = 32, NUM_KEYS = 6, KEY_W = 128;

  logic                      wb_clk_i = 1'b0;
  logic                      wb_rst_i = 1'b1;
  logic [NM*AW-1:0]          m_adr_i;
  logic [NM*DW-1:0]          m_dat_i;
  logic [NM*4-1:0]           m_sel_i;
  logic [NM*3-1:0]           m_cti_i;
  logic [NM*2-1:0]           m_bte_i;
  logic [NM-1:0]             m_cyc_i, m_stb_i, m_we_i;
  logic [DW-1:0]             m_dat_o;
  logic [NM-1:0]             m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]             s_adr_o;
  logic [DW-1:0]             s_dat_o;
  logic [3:0]                s_sel_o;
  logic [2:0]                s_cti_o;
  logic [1:0]                s_bte_o;
  logic                      s_cyc_o, s_stb_o, s_we_o;
  logic [DW-1:0]             s_dat_i;
  logic                      s_ack_i, s_err_i;
  logic [NUM_KEYS*KEY_W-1:0] keys_o;
  logic                      key_locked_o;

  int                        n_checks = 0;
  int                        n_pass   = 0;
  logic [NUM_KEYS*KEY_W-1:0] exp_keys;

  wb_keyreg_arb dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
    .m_bte_i(m_bte_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .keys_o(keys_o), .key_locked_o(key_locked_o)
  );

  // clock / reset
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [31:0] ram_dat(input logic [31:0] adr);
    return 32'hC0DE0000 ^ adr;
  endfunction

  // RAM model: zero-wait ack, data derived from the address.
  always @(posedge wb_clk_i) begin
    #2;
    s_ack_i = s_cyc_o & s_stb_o & !s_ack_i;
    s_dat_i = s_ack_i ? ram_dat(s_adr_o) : '0;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver: one single transfer from master m, starting in IDLE
  task automatic access(input int m, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we,
                        output logic [NM-1:0] ack, output logic [NM-1:0] err,
                        output logic [31:0] rdat, output int lat, output logic s_seen);
    ack = '0; err = '0; rdat = '0; lat = 0; s_seen = 1'b0;
    @(posedge wb_clk_i); #1;
    m_adr_i[m*AW +: AW] = adr;
    m_dat_i[m*DW +: DW] = dat;
    m_sel_i[m*4 +: 4]   = sel;
    m_we_i[m]  = we;
    m_cyc_i[m] = 1'b1;
    m_stb_i[m] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge wb_clk_i);
      if (s_cyc_o) s_seen = 1'b1;
      if ((m_ack_o | m_err_o) != '0) begin
        ack = m_ack_o; err = m_err_o; rdat = m_dat_o; lat = n;
        break;
      end
    end
    @(posedge wb_clk_i); #1;
    m_cyc_i[m] = 1'b0;
    m_stb_i[m] = 1'b0;
    m_we_i[m]  = 1'b0;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic xact(input string tag, input int m, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel, input logic we,
                      input logic exp_err, input int exp_lat, input logic exp_s,
                      input logic chk_dat, input logic [31:0] exp_dat);
    logic [NM-1:0] ack, err, onehot;
    logic [31:0]   rdat;
    int            lat;
    logic          s_seen;
    access(m, adr, dat, sel, we, ack, err, rdat, lat, s_seen);
    onehot = NM'(1) << m;
    check({tag, "_resp"}, {err, ack}, exp_err ? {onehot, {NM{1'b0}}} : {{NM{1'b0}}, onehot});
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_slave"}, s_seen, exp_s);
    if (chk_dat) check({tag, "_dat"}, rdat, exp_dat);
  endtask

  task automatic check_keys(input string tag);
    for (int k = 0; k < NUM_KEYS; k++)
      check($sformatf("%s_key%0d", tag, k), keys_o[k*KEY_W +: KEY_W], exp_keys[k*KEY_W +: KEY_W]);
  endtask

  int            owner_seq[4] = '{0, 1, 2, 0};
  int            exp_m, glat;
  logic [NM-1:0] got;
  logic [31:0]   gadr, gdat;

  initial begin
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_cti_i = '0; m_bte_i = '0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    s_ack_i = 1'b0; s_dat_i = '0; s_err_i = 1'b0;
    exp_keys = '0;

    // power-on reset
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("por_keys", {127'd0, |keys_o}, 128'd0);
    check("por_ack", {m_err_o, m_ack_o, s_cyc_o, s_stb_o}, 128'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;

    // load a key and the lock, then reset in the middle of an M1 ownership
    xact("pre_key", 0, 32'h80000, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 3, 1'b0, 1'b0, 32'h0);
    xact("pre_lock", 0, 32'h80060, 32'h1, 4'hF, 1'b1, 1'b0, 3, 1'b0, 1'b0, 32'h0);
    check("pre_locked", key_locked_o, 1'b1);
    check("pre_key0", keys_o[31:0], 32'hCAFEF00D);
    @(posedge wb_clk_i); #1;
    m_adr_i[1*AW +: AW] = 32'h200; m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("rst_keys", {127'd0, |keys_o}, 128'd0);
    check("rst_locked", key_locked_o, 1'b0);
    check("rst_resp", {m_err_o, m_ack_o}, 128'd0);
    check("rst_slave", {s_cyc_o, s_stb_o}, 128'd0);
    repeat (3) @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    m_adr_i[0*AW +: AW] = 32'h300; m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
    m_adr_i[2*AW +: AW] = 32'h380; m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1;
    got = '0; gadr = '0; glat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge wb_clk_i);
      if (m_ack_o != '0) begin got = m_ack_o; gadr = s_adr_o; glat = n; break; end
    end
    check("rst_first_owner", got, 3'b001);
    check("rst_first_adr", gadr, 32'h300);
    check("rst_first_lat", glat, 2);
    @(posedge wb_clk_i); #1;
    m_cyc_i = '0; m_stb_i = '0;
    @(posedge wb_clk_i); #1;

    // full and partial byte-lane key writes, permission errors
    xact("wr_full", 0, 32'h80000, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 3, 1'b0, 1'b0, 32'h0);
    exp_keys[31:0] = 32'hDEADBEEF;
    check("wr_full_word", keys_o[31:0], 32'hDEADBEEF);
    xact("wr_part", 0, 32'h80004, 32'h11223344, 4'b0011, 1'b1, 1'b0, 3, 1'b0, 1'b0, 32'h0);
    exp_keys[63:32] = 32'h00003344;
    check("wr_part_word", keys_o[63:32], 32'h00003344);
    xact("m1_key_wr", 1, 32'h80000, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 3, 1'b0, 1'b0, 32'h0);
    xact("m1_lock_wr", 1, 32'h80060, 32'h1, 4'hF, 1'b1, 1'b1, 3, 1'b0, 1'b0, 32'h0);
    check("m1_lock_none", key_locked_o, 1'b0);
    xact("key5_w3", 0, 32'h8005C, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b0, 3, 1'b0, 1'b0, 32'h0);
    exp_keys[5*KEY_W + 96 +: 32] = 32'hA5A5A5A5;
    check_keys("after_wr");

    // M0 releases cyc one cycle after its key write was sampled
    @(posedge wb_clk_i); #1;
    m_adr_i[0*AW +: AW] = 32'h80008; m_dat_i[0*DW +: DW] = 32'h55667788;
    m_sel_i[3:0] = 4'hF; m_we_i[0] = 1'b1; m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("abort_pre_resp", {m_err_o, m_ack_o}, 128'd0);
    @(posedge wb_clk_i); #1;
    m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0; m_we_i[0] = 1'b0;
    @(negedge wb_clk_i);
    check("abort_gated", {m_err_o, m_ack_o}, 128'd0);
    @(negedge wb_clk_i);
    check("abort_idle", 128'(dut.state), 128'd0);
    check("abort_resp2", {m_err_o, m_ack_o}, 128'd0);
    exp_keys[95:64] = 32'h55667788;
    check("abort_commit", keys_o[95:64], 32'h55667788);
    @(posedge wb_clk_i); #1;

    // just below the window goes to RAM (also leaves M2 as last owner)
    xact("below_win", 2, 32'h0007FFFC, 32'h0, 4'hF, 1'b0, 1'b0, 2, 1'b1, 1'b1, ram_dat(32'h0007FFFC));

    // three masters hold RAM reads; ownership rotates 0,1,2,0
    @(posedge wb_clk_i); #1;
    for (int i = 0; i < NM; i++) m_adr_i[i*AW +: AW] = 32'h100 + 32'(4*i);
    m_we_i = '0; m_cyc_i = '1; m_stb_i = '1;
    for (int s = 0; s < 4; s++) begin
      got = '0; gadr = '0; gdat = '0;
      for (int n = 0; n < 10; n++) begin
        @(negedge wb_clk_i);
        if (m_ack_o != '0) begin got = m_ack_o; gadr = s_adr_o; gdat = m_dat_o; break; end
      end
      exp_m = owner_seq[s];
      check($sformatf("rr_owner%0d", s), got, NM'(1) << exp_m);
      check($sformatf("rr_adr%0d", s), gadr, 32'h100 + 32'(4*exp_m));
      check($sformatf("rr_dat%0d", s), gdat, ram_dat(32'h100 + 32'(4*exp_m)));
      @(posedge wb_clk_i); #1;
      m_cyc_i[exp_m] = 1'b0; m_stb_i[exp_m] = 1'b0;
      @(posedge wb_clk_i); #1;
      if (s == 0) begin m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; end
      @(negedge wb_clk_i);
      check($sformatf("rr_gap%0d", s), {s_cyc_o, |m_ack_o}, 128'd0);
    end
    @(posedge wb_clk_i); #1;

    // lock, then writes are refused; lock reads 1, keys read 0
    xact("lock_set", 0, 32'h80060, 32'h1, 4'hF, 1'b1, 1'b0, 3, 1'b0, 1'b0, 32'h0);
    check("lock_flag", key_locked_o, 1'b1);
    xact("wr_locked", 0, 32'h80010, 32'h12345678, 4'hF, 1'b1, 1'b1, 3, 1'b0, 1'b0, 32'h0);
    xact("lock_rd", 0, 32'h80060, 32'h0, 4'hF, 1'b0, 1'b0, 3, 1'b0, 1'b1, 32'h1);
    xact("key_rd", 0, 32'h80000, 32'h0, 4'hF, 1'b0, 1'b0, 3, 1'b0, 1'b1, 32'h0);

    // unmapped window addresses error; just above the window goes to RAM
    xact("unmapped", 0, 32'h80080, 32'h0, 4'hF, 1'b0, 1'b1, 3, 1'b0, 1'b0, 32'h0);
    xact("unmapped_top", 2, 32'h800FC, 32'h0, 4'hF, 1'b0, 1'b1, 3, 1'b0, 1'b0, 32'h0);
    xact("above_win", 1, 32'h80100, 32'h0, 4'hF, 1'b0, 1'b0, 2, 1'b1, 1'b1, ram_dat(32'h80100));
    check("lock_held", key_locked_o, 1'b1);
    check_keys("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_keyreg_arb.md
Name: wb_keyreg_arb

Overview:
Parametrised N-master Wishbone B3 arbiter with an embedded key/configuration register bank.
- Arbitrates NM masters onto one shared RAM slave port using round-robin arbitration.
- Decodes a key-register window and services hits in that window locally; they never reach RAM.
- Adds byte-select writes, a per-master write-permission mask, a sticky lock, optional readback and error responses.
- Sits between the CPU/debug/DMA masters and ram_wb_b3. The key bank drives the locking keys of the obfuscated cores.

Parameters:
NM, 3, number of masters
DW, 32, data width; key word size
AW, 32, address width
NUM_KEYS, 6, number of key registers
KEY_W, 128, bits per key; must be a multiple of DW
KEY_BASE, 20'h80000, window base, compared against adr[19:0]
KEY_WR_MASK, 1, bit i set = master i may write keys/lock
KEY_READBACK, 0, 1 = key words readable, 0 = key reads return 0

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
m_adr_i  in  NM*AW  master addresses, master i at [i*AW +: AW]
m_dat_i  in  NM*DW  master write data
m_sel_i  in  NM*4  byte selects
m_cti_i  in  NM*3  cycle type
m_bte_i  in  NM*2  burst type
m_cyc_i / m_stb_i / m_we_i  in  NM each  per-master cycle, strobe, write-enable
m_dat_o  out  DW  read data, shared by all masters
m_ack_o / m_err_o / m_rty_o  out  NM each  per-master ack, error, retry; m_rty_o tied to 0
s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o, s_we_o  out  as master  RAM slave request
s_dat_i  in  DW  RAM read data
s_ack_i / s_err_i  in  1 each  RAM ack, error
keys_o  out  NUM_KEYS*KEY_W  key k at [k*KEY_W +: KEY_W]
key_locked_o  out  1  sticky lock flag

Behaviour:
Reset:
- Async reset clears keys_o, key_locked_o, grant and ack_q to 0.
- Sets last_grant = NM-1, so master 0 wins first.
- All m_ack_o/m_err_o and s_cyc_o/s_stb_o are 0 during and after reset.

Arbiter FSM (IDLE, GRANT):
- IDLE: if any m_cyc_i is high, register grant = first requesting master after last_grant, in increasing index with wrap.
  - Go to GRANT and update last_grant. Grant takes effect the next cycle.
- GRANT: hold while m_cyc_i[grant] is high; no preemption.
  - When it drops, return to IDLE on that edge. This forces at least one IDLE cycle between owners.

Slave mux:
- In GRANT, all s_* outputs = the granted master's signals.
- s_cyc_o/s_stb_o are forced to 0 when the address hits the key window.
- In IDLE, all s_* outputs = 0.

Key window decode:
- KW = KEY_W/DW words per key.
- Word address of key k, word w = KEY_BASE + 4*(k*KW + w); w=0 is the LSW.
- Lock register at KEY_BASE + 4*NUM_KEYS*KW.
- Any other address from the lock address up to KEY_BASE+0xFF is unmapped.
- hit = GRANT & m_cyc_i & m_stb_i of the granted master & adr in [KEY_BASE, KEY_BASE+0xFF].

Local response:
- ack_q <= hit & !ack_q. Response is one cycle after stb, a single-cycle pulse, so back-to-back accesses take 2 cycles each.
- The response is err instead of ack when any of these holds:
  - write while locked;
  - write from a master not in KEY_WR_MASK;
  - access to an unmapped address.
- A write commits on the edge that sets ack_q, only if no err condition holds.
  - Byte-lane merge per m_sel_i bit.
- Lock register write with dat[0]=1 sets key_locked_o. Writing 0 has no effect; the lock is cleared only by reset.

Read data:
- Lock register reads {0, key_locked_o}.
- Key reads return the word if KEY_READBACK, else 0.
- m_dat_o = local read data during a local response, else s_dat_i.

Response gating:
- m_ack_o[i] = (grant==i) & GRANT & (local ack | s_ack_i); m_err_o likewise.
- Non-granted masters never see ack/err.

Boundary conditions:
- Granted master drops cyc while ack_q is pending: ack_q is cleared and the output stays gated.
  - The write already committed on the sampled edge stands.
- Reset mid-transaction: immediate clear; the partial key write is lost.
- Simultaneous requests: round-robin order only; no priority.

Test Plan:
1. Assert reset for 3 cycles mid-GRANT -> keys_o=0, key_locked_o=0, all acks 0, s_cyc_o=0; the first request after reset is granted to master 0.
2. M0 writes 0xDEADBEEF, sel=4'hF, to 0x80000 -> m_ack_o[0] one cycle after stb, keys_o[31:0]=DEADBEEF, s_cyc_o stays 0 throughout.
3. M0 writes 0x11223344, sel=4'b0011, to 0x80004 (previous contents 0) -> keys_o[63:32]=0x00003344; M1 write to 0x80000 -> m_err_o[1], key unchanged.
4. All three masters hold cyc for RAM reads at 0x100, each dropping cyc after its ack -> grant order 0,1,2,0, with one IDLE cycle between owners; s_adr_o follows the owner.
5. M0 writes 1 to 0x80060 -> key_locked_o=1; subsequent M0 write to 0x80010 -> err, no change; lock read returns 1; key read returns 0 with KEY_READBACK=0.
6. Read of unmapped 0x80080 -> err; M0 deasserts cyc the cycle after a key write stb -> no ack on any master, the write is committed, and the FSM returns to IDLE.
